control_unit_hw: RTL and testbench

- Hardwired control sequencer for the 32-bit single-bus datapath (System).
- Replaces the hand-driven testbench FSM: decodes IR and produces every datapath/memory strobe for instruction fetch, ldi, the conditional branch family (brzr/brnz/brpl/brmi), nop and halt.
- Stalls fetch on memory_done.
- Sits beside System; all outputs connect 1:1 to System control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/control_decode.sv | 71 +++++++
 rtl/control_unit_hw.sv | 145 ++++++++++++++
 tb/tb_control_unit_hw.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encoding and strobe bundle for the hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam int IR_WIDTH = 32;

  // IR field positions
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_C2_HI = 20;
  localparam int IR_C2_LO = 19;

  // Instruction opcodes
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation used for every address/immediate add
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_DEC    = 4'd4,
    S_LDI_T3 = 4'd5,
    S_LDI_T4 = 4'd6,
    S_LDI_T5 = 4'd7,
    S_BR_T3  = 4'd8,
    S_BR_T4  = 4'd9,
    S_BR_T5  = 4'd10,
    S_BR_T6  = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       zlo_out;
    logic       zhi_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       c_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       con_in;
    logic       outport_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       inc_pc;
    logic [4:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_en;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational map from sequencer state (plus CON_FF for the branch commit) to the strobe bundle.
module control_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ALU_OP = cpu_ctrl_pkg::ALU_ADD
) (
  input  state_t state,
  input  logic   con_ff_bit,
  output ctrl_t  ctrl
);

  // Each state drives at most one bus source (PCout, MDRout, Zlo_out, Cout, Rout or BAout).
  always_comb begin
    ctrl = '0;
    case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      S_T1: begin
        ctrl.zlo_out  = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.mdr_in   = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_en   = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_LDI_T3: begin
        ctrl.grb    = 1'b1;
        ctrl.ba_out = 1'b1;
        ctrl.y_in   = 1'b1;
      end
      S_LDI_T4: begin
        ctrl.c_out  = 1'b1;
        ctrl.z_in   = 1'b1;
        ctrl.alu_op = ALU_OP;
      end
      S_LDI_T5: begin
        ctrl.zlo_out = 1'b1;
        ctrl.gra     = 1'b1;
        ctrl.r_in    = 1'b1;
      end
      S_BR_T3: begin
        ctrl.gra    = 1'b1;
        ctrl.r_out  = 1'b1;
        ctrl.con_in = 1'b1;
      end
      S_BR_T4: begin
        ctrl.pc_out = 1'b1;
        ctrl.y_in   = 1'b1;
      end
      S_BR_T5: begin
        ctrl.c_out  = 1'b1;
        ctrl.z_in   = 1'b1;
        ctrl.alu_op = ALU_OP;
      end
      S_BR_T6: begin
        // The only Mealy term: the branch target is committed only when CON_FF says taken.
        ctrl.zlo_out = 1'b1;
        ctrl.pc_in   = con_ff_bit;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit_hw.sv
// Hardwired control sequencer: fetch (stalled by memory_done), decode, ldi, branch family, nop, halt.
module control_unit_hw
  import cpu_ctrl_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] ALU_ADD    = cpu_ctrl_pkg::ALU_ADD
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  con_ff_bit,
  input  logic                  memory_done,
  input  logic                  stop,
  output logic                  PCout,
  output logic                  MDRout,
  output logic                  Zlo_out,
  output logic                  Zhi_out,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Inport_out,
  output logic                  Cout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  CONin,
  output logic                  outport_in,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  IncPC,
  output logic [4:0]            opcode,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  output logic                  run,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  state_t     state;
  state_t     state_next;
  logic       set_illegal;
  logic [4:0] ir_op;
  ctrl_t      ctrl;

  assign ir_op = ir[IR_OP_HI:IR_OP_LO];

  // Condition code and operand fields are consumed by the datapath, not the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[IR_OP_LO-1:0];

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state   <= S_RST;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Fetch handshake: T1 holds its strobes until memory_done is seen high at a rising edge;
  // the repeated PC reload in T1 is harmless because Z does not change while stalled.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      S_RST: state_next = S_T0;
      S_T0:  state_next = S_T1;
      S_T1:  if (memory_done) state_next = S_T2;
      S_T2:  state_next = S_DEC;
      S_DEC: begin
        case (ir_op)
          OP_LDI:  state_next = S_LDI_T3;
          OP_BR:   state_next = S_BR_T3;
          OP_NOP:  state_next = stop ? S_HALT : S_T0;
          OP_HALT: state_next = S_HALT;
          default: begin
            state_next  = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_LDI_T3: state_next = S_LDI_T4;
      S_LDI_T4: state_next = S_LDI_T5;
      S_LDI_T5: state_next = stop ? S_HALT : S_T0;
      S_BR_T3:  state_next = S_BR_T4;
      S_BR_T4:  state_next = S_BR_T5;
      S_BR_T5:  state_next = S_BR_T6;
      S_BR_T6:  state_next = stop ? S_HALT : S_T0;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RST;
    endcase
  end

  control_decode #(
    .ALU_OP(ALU_ADD)
  ) u_decode (
    .state      (state),
    .con_ff_bit (con_ff_bit),
    .ctrl       (ctrl)
  );

  assign PCout            = ctrl.pc_out;
  assign MDRout           = ctrl.mdr_out;
  assign Zlo_out          = ctrl.zlo_out;
  assign Zhi_out          = ctrl.zhi_out;
  assign HIout            = ctrl.hi_out;
  assign LOout            = ctrl.lo_out;
  assign Inport_out       = ctrl.inport_out;
  assign Cout             = ctrl.c_out;
  assign MARin            = ctrl.mar_in;
  assign Zin              = ctrl.z_in;
  assign PCin             = ctrl.pc_in;
  assign MDRin            = ctrl.mdr_in;
  assign IRin             = ctrl.ir_in;
  assign Yin              = ctrl.y_in;
  assign HIin             = ctrl.hi_in;
  assign LOin             = ctrl.lo_in;
  assign CONin            = ctrl.con_in;
  assign outport_in       = ctrl.outport_in;
  assign Gra              = ctrl.gra;
  assign Grb              = ctrl.grb;
  assign Grc              = ctrl.grc;
  assign Rin              = ctrl.r_in;
  assign Rout             = ctrl.r_out;
  assign BAout            = ctrl.ba_out;
  assign IncPC            = ctrl.inc_pc;
  assign opcode           = ctrl.alu_op;
  assign Mem_Read         = ctrl.mem_read;
  assign Mem_Write        = ctrl.mem_write;
  assign Mem_enable512x32 = ctrl.mem_en;

  assign run       = (state != S_RST) && (state != S_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_control_unit_hw.sv
// Bench for control_unit_hw: a small single-bus datapath model runs directed programs under the sequencer.
module tb_control_unit_hw;
  import cpu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic clear = 1'b0;
  always #5 Clock = ~Clock;

  logic        memory_done = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] ir;
  logic        con_ff_bit;

  logic PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
  logic [4:0] opcode;
  logic Mem_Read, Mem_Write, Mem_enable512x32, run, illegal;
  logic [3:0] state_dbg;

  control_unit_hw dut (
    .Clock(Clock), .clear(clear), .ir(ir), .con_ff_bit(con_ff_bit),
    .memory_done(memory_done), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
    .HIout(HIout), .LOout(LOout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .opcode(opcode), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .run(run), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  logic [34:0] all_out;
  assign all_out = {PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Inport_out, Cout,
                    MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                    Gra, Grb, Grc, Rin, Rout, BAout, IncPC, opcode,
                    Mem_Read, Mem_Write, Mem_enable512x32, run, illegal};

  // ---------------- datapath model ----------------
  logic [31:0] mem [0:31];
  logic [31:0] m_r [0:15];
  logic [31:0] m_pc, m_mar, m_mdr, m_ir, m_y, m_z;
  logic        m_con;
  logic [31:0] bus, c_sext;
  logic [3:0]  sel;

  assign ir         = m_ir;
  assign con_ff_bit = m_con;
  assign c_sext     = {{13{m_ir[18]}}, m_ir[18:0]};

  always_comb begin
    sel = Gra ? m_ir[26:23] : Grb ? m_ir[22:19] : Grc ? m_ir[18:15] : 4'd0;
    bus = (PCout ? m_pc : 32'd0) | (MDRout ? m_mdr : 32'd0) | (Zlo_out ? m_z : 32'd0) |
          (Rout ? m_r[sel] : 32'd0) | ((BAout && sel != 4'd0) ? m_r[sel] : 32'd0) |
          (Cout ? c_sext : 32'd0);
  end

  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      m_pc <= 32'd0; m_mar <= 32'd0; m_mdr <= 32'd0; m_ir <= 32'd0;
      m_y <= 32'd0; m_z <= 32'd0; m_con <= 1'b0;
      for (int i = 0; i < 16; i++) m_r[i] <= 32'd0;
    end else begin
      if (MARin) m_mar <= bus;
      if (Zin)   m_z <= IncPC ? bus + 32'd1 : (opcode == 5'b00011) ? m_y + bus : 32'hDEAD_BEEF;
      if (PCin)  m_pc <= bus;
      if (MDRin) m_mdr <= (Mem_Read && Mem_enable512x32) ? mem[m_mar[4:0]] : bus;
      if (IRin)  m_ir <= bus;
      if (Yin)   m_y <= bus;
      if (Rin)   m_r[sel] <= bus;
      if (CONin) begin
        case (m_ir[20:19])
          2'b00: m_con <= (bus == 32'd0);
          2'b01: m_con <= (bus != 32'd0);
          2'b10: m_con <= ~bus[31];
          default: m_con <= bus[31];
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle structural checks while running
  logic mon_en = 1'b0;
  always @(negedge Clock) begin
    if (mon_en && clear) begin
      check("one_bus_driver",
            64'(int'(PCout) + int'(MDRout) + int'(Zlo_out) + int'(Zhi_out) + int'(HIout) +
                int'(LOout) + int'(Inport_out) + int'(Cout) + int'(Rout) + int'(BAout) <= 1), 64'd1);
      check("mem_write_zero", 64'(Mem_Write), 64'd0);
      if (state_dbg == S_LDI_T4 || state_dbg == S_BR_T5)
        check("alu_add_op", 64'(opcode), 64'd3);
      else
        check("alu_op_idle", 64'(opcode), 64'd0);
      if (state_dbg == S_HALT)
        check("halt_quiet", 64'({run, MARin, PCin, IRin}), 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_ldi(input logic [3:0] ra, input logic [18:0] c);
    return {5'b00001, ra, 4'd0, c};
  endfunction

  function automatic logic [31:0] enc_br(input logic [3:0] ra, input logic [1:0] c2, input logic [18:0] c);
    return {5'b10011, ra, 2'b00, c2, c};
  endfunction

  localparam logic [31:0] W_NOP  = {5'b11010, 27'd0};
  localparam logic [31:0] W_HALT = {5'b11011, 27'd0};
  localparam logic [31:0] W_ILL  = {5'b11111, 27'd0};

  typedef struct {
    string            name;
    logic [3:0][4:0]  addr;
    logic [3:0][31:0] word;
    int               nw;
    logic             stop;
    int               exp_cycles;
    logic [31:0]      exp_mar;
    logic [31:0]      exp_r5;
    logic             exp_ill;
  } scen_t;

  function automatic scen_t mk(input string name, input int nw,
                               input logic [4:0] a0, input logic [31:0] w0,
                               input logic [4:0] a1, input logic [31:0] w1,
                               input logic [4:0] a2, input logic [31:0] w2,
                               input logic [4:0] a3, input logic [31:0] w3,
                               input logic st, input int cyc, input logic [31:0] mar,
                               input logic [31:0] r5, input logic ill);
    scen_t s;
    s.name = name; s.nw = nw;
    s.addr[0] = a0; s.word[0] = w0; s.addr[1] = a1; s.word[1] = w1;
    s.addr[2] = a2; s.word[2] = w2; s.addr[3] = a3; s.word[3] = w3;
    s.stop = st; s.exp_cycles = cyc; s.exp_mar = mar; s.exp_r5 = r5; s.exp_ill = ill;
    return s;
  endfunction

  task automatic load_and_reset(input scen_t s);
    mon_en = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    for (int i = 0; i < s.nw; i++) mem[s.addr[i]] = s.word[i];
    @(negedge Clock);
    @(negedge Clock);
    check({s.name, "_rst_state"}, 64'(state_dbg), 64'(S_RST));
    check({s.name, "_rst_outputs"}, 64'(all_out), 64'd0);
    mon_en = 1'b1;
    clear = 1'b1;
  endtask

  scen_t tbl [8];
  int    cyc;
  int    ir_cnt;
  logic  seen;

  initial begin
    tbl[0] = mk("brzr_taken", 3, 5'd0, enc_ldi(4'd5, 19'd0), 5'd1, enc_br(4'd5, 2'b00, 19'd14),
                5'd16, W_HALT, 5'd0, 32'd0, 1'b0, 19, 32'd16, 32'd0, 1'b0);
    tbl[1] = mk("brzr_not_brpl", 4, 5'd0, enc_ldi(4'd5, 19'd3), 5'd1, enc_br(4'd5, 2'b00, 19'd14),
                5'd2, enc_br(4'd5, 2'b10, 19'd14), 5'd17, W_HALT, 1'b0, 27, 32'd17, 32'd3, 1'b0);
    tbl[2] = mk("brmi_taken", 3, 5'd0, enc_ldi(4'd5, 19'h7FFFD), 5'd1, enc_br(4'd5, 2'b11, 19'd14),
                5'd16, W_HALT, 5'd0, 32'd0, 1'b0, 19, 32'd16, 32'hFFFF_FFFD, 1'b0);
    tbl[3] = mk("brnz_not", 3, 5'd0, enc_ldi(4'd5, 19'd0), 5'd1, enc_br(4'd5, 2'b01, 19'd14),
                5'd2, W_HALT, 5'd0, 32'd0, 1'b0, 19, 32'd2, 32'd0, 1'b0);
    tbl[4] = mk("nop_halt", 2, 5'd0, W_NOP, 5'd1, W_HALT, 5'd0, 32'd0, 5'd0, 32'd0,
                1'b0, 8, 32'd1, 32'd0, 1'b0);
    tbl[5] = mk("illegal", 1, 5'd0, W_ILL, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                1'b0, 4, 32'd0, 32'd0, 1'b1);
    tbl[6] = mk("stop_after_ldi", 2, 5'd0, enc_ldi(4'd5, 19'd7), 5'd1, W_HALT, 5'd0, 32'd0,
                5'd0, 32'd0, 1'b1, 7, 32'd0, 32'd7, 1'b0);
    tbl[7] = mk("stop_after_nop", 2, 5'd0, W_NOP, 5'd1, W_HALT, 5'd0, 32'd0, 5'd0, 32'd0,
                1'b1, 4, 32'd0, 32'd0, 1'b0);

    // ---- table-driven programs ----
    for (int t = 0; t < 8; t++) begin
      stop = tbl[t].stop;
      memory_done = 1'b1;
      load_and_reset(tbl[t]);
      cyc = 0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge Clock);
        if (state_dbg == S_HALT) seen = 1'b1;
        else cyc++;
      end
      check({tbl[t].name, "_reached_halt"}, 64'(seen), 64'd1);
      check({tbl[t].name, "_cycles"}, 64'(cyc), 64'(tbl[t].exp_cycles));
      check({tbl[t].name, "_mar"}, 64'(m_mar), 64'(tbl[t].exp_mar));
      check({tbl[t].name, "_r5"}, 64'(m_r[5]), 64'(tbl[t].exp_r5));
      check({tbl[t].name, "_illegal"}, 64'(illegal), 64'(tbl[t].exp_ill));
      check({tbl[t].name, "_run"}, 64'(run), 64'd0);
    end
    stop = 1'b0;

    // ---- fetch stall: memory_done low for three T1 cycles ----
    memory_done = 1'b0;
    load_and_reset(mk("stall", 1, 5'd0, W_HALT, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                      1'b0, 0, 32'd0, 32'd0, 1'b0));
    @(negedge Clock);
    check("stall_t0", 64'({PCout, MARin, IncPC, Zin}), 64'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("stall_in_t1", 64'(state_dbg), 64'(S_T1));
      check("stall_t1_strobes", 64'({MDRin, Mem_Read, Mem_enable512x32, PCin}), 64'hF);
      if (i == 3) memory_done = 1'b1;
    end
    ir_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (IRin) ir_cnt++;
    end
    check("stall_irin_once", 64'(ir_cnt), 64'd1);
    check("stall_halted", 64'(state_dbg), 64'(S_HALT));

    // ---- clear pulsed during BR_T4 ----
    load_and_reset(tbl[0]);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge Clock);
      if (state_dbg == S_BR_T4) seen = 1'b1;
    end
    check("clr_reached_br_t4", 64'(seen), 64'd1);
    #2;
    mon_en = 1'b0;
    clear = 1'b0;
    #1;
    check("clr_outputs_zero", 64'(all_out), 64'd0);
    check("clr_state_rst", 64'(state_dbg), 64'(S_RST));
    @(negedge Clock);
    check("clr_held_rst", 64'(state_dbg), 64'(S_RST));
    clear = 1'b1;
    #1;
    check("clr_first_cycle_rst", 64'(state_dbg), 64'(S_RST));
    @(negedge Clock);
    check("clr_then_t0", 64'(state_dbg), 64'(S_T0));
    check("clr_t0_pcout", 64'({PCout, MARin, illegal}), 64'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
